spi_byte_sequencer: RTL

- Avalon-MM style bus master sitting directly upstream of the SPI master core (8-bit, CPOL0/CPHA0, one slave). It drives that core's register port.
- Converts a ready/valid TX byte stream with packet framing into register accesses: SSO on, status poll, txdata write, rxdata read, SSO off.
- Returns each received byte on a ready/valid RX stream, so the CPU no longer babysits byte-level SPI traffic.

---
 rtl/spi_byte_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: turns a framed ready/valid TX byte stream into register
// accesses on an SPI master core (SSO on, status polls, txdata write, rxdata
// read, SSO off) and returns each received byte on a ready/valid RX stream.
module spi_byte_sequencer #(
    parameter int unsigned POLL_TIMEOUT = 4096,
    parameter logic [15:0] SS_MASK      = 16'h0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_last,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_last,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    output logic [2:0]  spi_mem_addr,
    output logic [15:0] spi_data_from_cpu,
    input  logic [15:0] spi_data_to_cpu,
    output logic        spi_select,
    output logic        spi_read_n,
    output logic        spi_write_n
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SEL     = 4'd1,
        ST_SSON    = 4'd2,
        ST_WAIT_TX = 4'd3,
        ST_POLL_T  = 4'd4,
        ST_WR      = 4'd5,
        ST_POLL_R  = 4'd6,
        ST_RD      = 4'd7,
        ST_OUT     = 4'd8,
        ST_POLL_E  = 4'd9,
        ST_CLR_ST  = 4'd10,
        ST_SSOFF   = 4'd11
    } state_t;

    // Outcome of one completed status read.
    localparam logic [1:0] PD_AGAIN   = 2'd0;
    localparam logic [1:0] PD_ERR     = 2'd1;
    localparam logic [1:0] PD_READY   = 2'd2;
    localparam logic [1:0] PD_TIMEOUT = 2'd3;

    localparam logic [12:0] POLL_LIMIT = 13'(POLL_TIMEOUT);

    // States that run a 3-cycle bus access; the others just wait on a stream.
    function automatic logic is_access(input state_t s);
        case (s)
            ST_IDLE, ST_WAIT_TX, ST_OUT: is_access = 1'b0;
            default:                     is_access = 1'b1;
        endcase
    endfunction

    function automatic logic is_read(input state_t s);
        case (s)
            ST_POLL_T, ST_POLL_R, ST_POLL_E, ST_RD: is_read = 1'b1;
            default:                                is_read = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] addr_of(input state_t s);
        case (s)
            ST_SEL:                         addr_of = 3'd5;
            ST_SSON, ST_SSOFF:              addr_of = 3'd3;
            ST_POLL_T, ST_POLL_R, ST_POLL_E,
            ST_CLR_ST:                      addr_of = 3'd2;
            ST_WR:                          addr_of = 3'd1;
            default:                        addr_of = 3'd0;
        endcase
    endfunction

    function automatic logic [15:0] wdata_of(input state_t s, input logic [7:0] byte_in);
        case (s)
            ST_SEL:  wdata_of = SS_MASK;
            ST_SSON: wdata_of = 16'h0400;
            ST_WR:   wdata_of = {8'h00, byte_in};
            default: wdata_of = 16'h0000;
        endcase
    endfunction

    // ROE/TOE take priority so the core status gets cleared before moving on.
    function automatic logic [1:0] poll_decide(input logic [15:0] st,
                                               input logic [3:0]  ready_bit,
                                               input logic        at_limit);
        if ((st[4] | st[3]) == 1'b1) begin
            poll_decide = PD_ERR;
        end else if (st[ready_bit] == 1'b1) begin
            poll_decide = PD_READY;
        end else if (at_limit) begin
            poll_decide = PD_TIMEOUT;
        end else begin
            poll_decide = PD_AGAIN;
        end
    endfunction

    state_t      state_r, state_s;
    state_t      ret_r, ret_s;
    state_t      ready_next_s;
    logic [1:0]  phase_r, phase_s;
    logic [12:0] cnt_r, cnt_s, cnt_inc_s;
    logic [3:0]  ready_bit_s;
    logic        at_limit_s;
    logic        set_err_s;
    logic        take_tx_s;
    logic        cap_rx_s;
    logic        last_r;

    logic        tx_ready_r;
    logic [7:0]  rx_data_r;
    logic        rx_last_r;
    logic        rx_valid_r;
    logic        busy_r;
    logic        err_r;
    logic [2:0]  spi_mem_addr_r;
    logic [15:0] spi_data_from_cpu_r;
    logic        spi_select_r;
    logic        spi_read_n_r;
    logic        spi_write_n_r;

    // Next-state, poll bookkeeping and event strobes for the packet FSM.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        ret_s     = ret_r;
        cnt_s     = cnt_r;
        set_err_s = 1'b0;
        take_tx_s = 1'b0;
        cap_rx_s  = 1'b0;
        cnt_inc_s = (cnt_r == 13'h1FFF) ? cnt_r : (cnt_r + 13'd1);
        at_limit_s = (cnt_inc_s >= POLL_LIMIT);

        case (state_r)
            ST_POLL_T: begin
                ready_bit_s  = 4'd6;
                ready_next_s = ST_WR;
            end
            ST_POLL_R: begin
                ready_bit_s  = 4'd7;
                ready_next_s = ST_RD;
            end
            default: begin
                ready_bit_s  = 4'd5;
                ready_next_s = ST_SSOFF;
            end
        endcase

        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_s = ST_SEL;
                    phase_s = 2'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_TX: begin
                // The poll counter stays parked while the source has no byte.
                if (tx_valid) begin
                    state_s = ST_POLL_T;
                    phase_s = 2'd0;
                    cnt_s   = 13'd0;
                end else begin
                    state_s = ST_WAIT_TX;
                end
            end
            ST_OUT: begin
                if (rx_ready) begin
                    state_s = rx_last_r ? ST_POLL_E : ST_WAIT_TX;
                    phase_s = 2'd0;
                    cnt_s   = 13'd0;
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_POLL_T, ST_POLL_R, ST_POLL_E: begin
                if (phase_r != 2'd2) begin
                    phase_s = phase_r + 2'd1;
                end else begin
                    phase_s = 2'd0;
                    case (poll_decide(spi_data_to_cpu, ready_bit_s, at_limit_s))
                        PD_ERR: begin
                            set_err_s = 1'b1;
                            cnt_s     = cnt_inc_s;
                            ret_s     = state_r;
                            state_s   = ST_CLR_ST;
                        end
                        PD_READY: begin
                            cnt_s     = 13'd0;
                            state_s   = ready_next_s;
                            take_tx_s = (state_r == ST_POLL_T);
                        end
                        PD_TIMEOUT: begin
                            // A byte waiting in POLL_T is still swallowed.
                            set_err_s = 1'b1;
                            state_s   = ST_SSOFF;
                            take_tx_s = (state_r == ST_POLL_T);
                        end
                        default: begin
                            cnt_s = cnt_inc_s;
                        end
                    endcase
                end
            end
            ST_SEL, ST_SSON, ST_WR, ST_RD, ST_CLR_ST, ST_SSOFF: begin
                if (phase_r != 2'd2) begin
                    phase_s = phase_r + 2'd1;
                end else begin
                    phase_s = 2'd0;
                    case (state_r)
                        ST_SEL:    state_s = ST_SSON;
                        ST_SSON:   state_s = ST_WAIT_TX;
                        ST_WR: begin
                            state_s = ST_POLL_R;
                            cnt_s   = 13'd0;
                        end
                        ST_RD: begin
                            state_s  = ST_OUT;
                            cap_rx_s = 1'b1;
                        end
                        ST_CLR_ST: state_s = ret_r;
                        default:   state_s = ST_IDLE;
                    endcase
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = 2'd0;
            end
        endcase
    end

    // State and registered outputs; bus strobes are decoded from the next state
    // so each access shows two strobed cycles followed by one idle cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r             <= ST_IDLE;
            ret_r               <= ST_IDLE;
            phase_r             <= 2'd0;
            cnt_r               <= 13'd0;
            last_r              <= 1'b0;
            tx_ready_r          <= 1'b0;
            rx_data_r           <= 8'h00;
            rx_last_r           <= 1'b0;
            rx_valid_r          <= 1'b0;
            busy_r              <= 1'b0;
            err_r               <= 1'b0;
            spi_mem_addr_r      <= 3'd0;
            spi_data_from_cpu_r <= 16'h0000;
            spi_select_r        <= 1'b0;
            spi_read_n_r        <= 1'b1;
            spi_write_n_r       <= 1'b1;
        end else begin
            state_r    <= state_s;
            ret_r      <= ret_s;
            phase_r    <= phase_s;
            cnt_r      <= cnt_s;
            tx_ready_r <= take_tx_s;
            rx_valid_r <= (state_s == ST_OUT);
            busy_r     <= (state_s != ST_IDLE);
            err_r      <= set_err_s | (err_r & ~err_clr);
            if (take_tx_s) begin
                last_r <= tx_last;
            end
            if (cap_rx_s) begin
                rx_data_r <= spi_data_to_cpu[7:0];
                rx_last_r <= last_r;
            end
            if (is_access(state_s)) begin
                spi_select_r   <= (phase_s != 2'd2);
                spi_read_n_r   <= ~(is_read(state_s) & (phase_s != 2'd2));
                spi_write_n_r  <= ~(~is_read(state_s) & (phase_s != 2'd2));
                spi_mem_addr_r <= addr_of(state_s);
                if (!is_read(state_s) && (phase_s == 2'd0)) begin
                    spi_data_from_cpu_r <= wdata_of(state_s, tx_data);
                end
            end else begin
                spi_select_r  <= 1'b0;
                spi_read_n_r  <= 1'b1;
                spi_write_n_r <= 1'b1;
            end
        end
    end

    assign tx_ready          = tx_ready_r;
    assign rx_data           = rx_data_r;
    assign rx_last           = rx_last_r;
    assign rx_valid          = rx_valid_r;
    assign busy              = busy_r;
    assign err               = err_r;
    assign spi_mem_addr      = spi_mem_addr_r;
    assign spi_data_from_cpu = spi_data_from_cpu_r;
    assign spi_select        = spi_select_r;
    assign spi_read_n        = spi_read_n_r;
    assign spi_write_n       = spi_write_n_r;

endmodule
